spec_readout: RTL

- Downstream of the spectrum accumulator stage; consumes the accumulated power spectra it leaves in the dual-port RAM (DPRAM).
- After a frame of pulses has been accumulated, walks DPRAM port B over every range bin and FFT index, then streams the 32-bit words to the host-side output FIFO.
- Uses a valid/ready handshake and absorbs backpressure through a small skid FIFO that covers the RAM read latency.

---
 rtl/spec_pkg.sv | 25 ++
 rtl/spec_skid_fifo.sv | 58 +++++
 rtl/spec_readout.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/spec_pkg.sv
// Shared definitions for the spectrum readout block: address geometry,
// word width, readout FSM states and the {bin, idx} address packer.
package spec_pkg;

    localparam int N_PTS    = 1024;
    localparam int MAX_BINS = 16;
    localparam int IDX_W    = $clog2(N_PTS);
    localparam int BIN_W    = $clog2(MAX_BINS);
    localparam int ADDR_W   = BIN_W + IDX_W;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    // DPRAM port-B address: range bin in the upper field, FFT index below.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [BIN_W-1:0] bin,
                                                    input logic [IDX_W-1:0] idx);
        return {bin, idx};
    endfunction

endpackage

// File: rtl/spec_skid_fifo.sv
// Small synchronous FIFO that absorbs DPRAM read latency under backpressure.
// The head entry is presented from storage flops; o_data is forced to zero
// whenever the FIFO is empty so the output port is clean after reset.
// Simultaneous push and pop leaves the occupancy unchanged, allowing one
// word per cycle of sustained throughput.
module spec_skid_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_valid;
    logic              w_pop;

    assign w_pop       = i_pop && r_valid;
    assign w_count_nxt = r_count + CNT_W'(i_push) - CNT_W'(w_pop);

    // Pointer and occupancy bookkeeping; cleared on reset to flush the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_valid ? r_mem[r_rd_ptr] : '0;
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule

// File: rtl/spec_readout.sv
// Spectrum readout: after a frame is accumulated, walks DPRAM port B over
// every {bin, idx} address and streams the words out through a skid FIFO
// with a valid/ready handshake.
// Optional build macro SPEC_READOUT_CLEAR_EN adds a write-back port that
// zeroes each location RD_LAT+1 cycles after it has been read.
module spec_readout
    import spec_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int SKID_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BIN_W:0]     num_bins,
    output logic [ADDR_W-1:0]  rdaddr_out,
    output logic               rden_out,
    input  logic [DATA_W-1:0]  rddata_in,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic               busy,
`ifdef SPEC_READOUT_CLEAR_EN
    output logic [ADDR_W-1:0]  clr_addr_out,
    output logic               clr_we_out,
`endif
    output logic               done
);

    localparam int CNT_W = $clog2(SKID_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BIN_W:0]     r_nb;
    logic [BIN_W:0]     w_nb_m1;
    logic [BIN_W-1:0]   r_bin;
    logic [IDX_W-1:0]   r_idx;
    logic [ADDR_W-1:0]  r_wcnt;
    logic [ADDR_W-1:0]  w_last_ord;
    logic [RD_LAT-1:0]  r_vld_p;
    logic [CNT_W-1:0]   w_occ;
    logic [CNT_W-1:0]   w_inflight;
    logic [SUM_W-1:0]   w_pending;
    logic               w_start_ok;
    logic               w_room;
    logic               w_last_addr;
    logic               w_rden;
    logic               w_pop;

    assign w_start_ok  = start && (num_bins != '0) && (num_bins <= (BIN_W+1)'(MAX_BINS));
    assign w_nb_m1     = r_nb - (BIN_W+1)'(1);
    assign w_last_addr = (r_bin == w_nb_m1[BIN_W-1:0]) && (r_idx == '1);
    assign w_last_ord  = pack_addr(w_nb_m1[BIN_W-1:0], '1);
    // Words queued plus words still coming back from the RAM must never
    // exceed the FIFO depth, so a read is only issued when there is room.
    assign w_pending   = SUM_W'(w_occ) + SUM_W'(w_inflight);
    assign w_room      = w_pending < SUM_W'(SKID_DEPTH);
    assign w_pop       = dout_valid && dout_ready;

    assign rden_out    = w_rden;
    assign rdaddr_out  = pack_addr(r_bin, r_idx);
    assign dout_last   = dout_valid && (r_wcnt == w_last_ord);
    assign busy        = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign done        = (r_state == ST_FINISH);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and read-enable decode.
    always_comb begin
        w_state_nxt = r_state;
        w_rden      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_nxt = ST_READ;
            end
            ST_READ: begin
                if (w_room) begin
                    w_rden = 1'b1;
                    if (w_last_addr) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && dout_last) w_state_nxt = ST_FINISH;
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Frame bookkeeping: latched bin count, read address walk, output word count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nb   <= '0;
            r_bin  <= '0;
            r_idx  <= '0;
            r_wcnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_start_ok) begin
                r_nb   <= num_bins;
                r_bin  <= '0;
                r_idx  <= '0;
                r_wcnt <= '0;
            end
            if (w_rden) begin
                r_idx <= r_idx + IDX_W'(1);
                if (r_idx == '1) r_bin <= r_bin + BIN_W'(1);
            end
            if (w_pop) r_wcnt <= r_wcnt + ADDR_W'(1);
        end
    end

    // Valid shift register tracking reads still inside the RAM pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= w_rden;
            for (int i = 1; i < RD_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
        end
    end

    // Number of reads currently in flight.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CNT_W'(r_vld_p[i]);
    end

    spec_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (SKID_DEPTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_vld_p[RD_LAT-1]),
        .i_data  (rddata_in),
        .i_pop   (w_pop),
        .o_data  (dout),
        .o_valid (dout_valid),
        .o_count (w_occ)
    );

`ifdef SPEC_READOUT_CLEAR_EN
    logic [ADDR_W-1:0] r_caddr_p [RD_LAT+1];
    logic              r_cwe;

    // Delay each read address so the zero write lands RD_LAT+1 cycles after its read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= RD_LAT; i++) r_caddr_p[i] <= '0;
            r_cwe <= 1'b0;
        end else begin
            r_caddr_p[0] <= rdaddr_out;
            for (int i = 1; i <= RD_LAT; i++) r_caddr_p[i] <= r_caddr_p[i-1];
            r_cwe <= r_vld_p[RD_LAT-1];
        end
    end

    assign clr_addr_out = r_caddr_p[RD_LAT];
    assign clr_we_out   = r_cwe;
`endif

endmodule
